// File: rtl/hist_remap_if.sv
// rtl/hist_remap_if.sv - histogram snapshot, video in/out and status signals of hist_remap
interface hist_remap_if;
    logic [63:0] id_value;
    logic        id_clear;
    logic        frame_end;
    logic [7:0]  video_data;
    logic        video_valid;
    logic [7:0]  remap_data;
    logic        remap_valid;
    logic        busy;
    logic        lut_update;
    logic        frame_drop;

    modport slave (
        input  id_value, frame_end, video_data, video_valid,
        output id_clear, remap_data, remap_valid, busy, lut_update, frame_drop
    );

    modport master (
        output id_value, frame_end, video_data, video_valid,
        input  id_clear, remap_data, remap_valid, busy, lut_update, frame_drop
    );
endinterface

// File: rtl/hist_remap.sv
// rtl/hist_remap.sv - histogram equalisation: CDF LUT build with sequential divider and interpolating pixel remap
module hist_remap #(
    parameter bit CLEAR_EN  = 1'b1,
    parameter bit INTERP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    hist_remap_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_ACCUM,
        S_DIV,
        S_COMMIT
    } state_t;

    function automatic logic [8:0] ident(input logic [2:0] i);
        return 9'({i, 5'd0}) + 9'd32;
    endfunction

    state_t      state;
    state_t      state_nx;
    logic [2:0]  bin_idx;
    logic [3:0]  bit_idx;
    logic [7:0]  snap [8];
    logic [10:0] cdf [8];
    logic [10:0] cdf_sum;
    logic [10:0] total;
    logic [19:0] rem;
    logic [19:0] rem_cur;
    logic [19:0] rem_nx;
    logic [19:0] dsh;
    logic [3:0]  shamt;
    logic        q_bit;
    logic [7:0]  quo;
    logic [8:0]  lut_act [8];
    logic [8:0]  lut_shd [8];
    logic        busy;
    logic        id_clear;
    logic        lut_update;
    logic        frame_drop_q;

    // ------------------------------------------------------------------
    // Build FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        id_clear   = 1'b0;
        lut_update = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.frame_end) begin
                    state_nx = S_SNAP;
                end
            end
            S_SNAP: begin
                busy     = 1'b1;
                id_clear = CLEAR_EN;
                state_nx = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (bin_idx == 3'd7) begin
                    state_nx = S_DIV;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (bin_idx == 3'd7 && bit_idx == 4'd8) begin
                    state_nx = S_COMMIT;
                end
            end
            S_COMMIT: begin
                busy       = 1'b1;
                lut_update = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // CDF accumulation and restoring divide: one quotient bit per cycle,
    // bits 8..0, quotient never exceeds 256 so 9 bits suffice.
    // ------------------------------------------------------------------
    assign total   = cdf[7];
    assign cdf_sum = ((bin_idx == 3'd0) ? 11'd0 : cdf[bin_idx - 3'd1]) + {3'd0, snap[bin_idx]};
    assign rem_cur = (bit_idx == 4'd0) ? {1'b0, cdf[bin_idx], 8'd0} : rem;
    assign shamt   = 4'd8 - bit_idx;
    assign dsh     = 20'(total) << shamt;
    assign q_bit   = (rem_cur >= dsh);
    assign rem_nx  = q_bit ? (rem_cur - dsh) : rem_cur;

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.frame_end) begin
            for (int k = 0; k < 8; k++) begin
                snap[k] <= bus.id_value[8*k +: 8];
            end
        end
        if (state == S_ACCUM) begin
            cdf[bin_idx] <= cdf_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_idx <= '0;
            bit_idx <= '0;
            rem     <= '0;
            quo     <= '0;
            for (int k = 0; k < 8; k++) begin
                lut_act[k] <= ident(3'(k));
                lut_shd[k] <= ident(3'(k));
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.frame_end) begin
                        bin_idx <= '0;
                        bit_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    bin_idx <= bin_idx + 3'd1;
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[6:0], q_bit};
                    if (bit_idx == 4'd8) begin
                        bit_idx <= '0;
                        bin_idx <= bin_idx + 3'd1;
                        // An empty histogram carries no distribution: fall back to identity.
                        lut_shd[bin_idx] <= (total == 11'd0) ? ident(bin_idx) : {quo, q_bit};
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_COMMIT: begin
                    for (int k = 0; k < 8; k++) begin
                        lut_act[k] <= lut_shd[k];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_drop_q <= 1'b0;
        end else begin
            frame_drop_q <= bus.frame_end && (state != S_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // Pixel path: stage 1 looks up the bin edges, stage 2 interpolates.
    // ------------------------------------------------------------------
    logic [2:0]  pix_b;
    logic [8:0]  pix_l;
    logic [8:0]  pix_u;
    logic        s1_valid;
    logic [4:0]  s1_f;
    logic [8:0]  s1_l;
    logic [8:0]  s1_d;
    logic [13:0] prod;
    logic [9:0]  sum;
    logic [7:0]  sat;
    logic        out_valid;
    logic [7:0]  out_data;

    assign pix_b = bus.video_data[7:5];
    assign pix_u = lut_act[pix_b];
    assign pix_l = (pix_b == 3'd0) ? 9'd0 : lut_act[pix_b - 3'd1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
            s1_l     <= '0;
            s1_d     <= '0;
        end else begin
            s1_valid <= bus.video_valid;
            if (bus.video_valid) begin
                s1_f <= bus.video_data[4:0];
                s1_l <= pix_l;
                s1_d <= pix_u - pix_l;
            end
        end
    end

    assign prod = 14'(s1_d) * 14'(s1_f);
    assign sum  = {1'b0, s1_l} + (INTERP_EN ? {1'b0, prod[13:5]} : {1'b0, s1_d});
    assign sat  = (sum > 10'd255) ? 8'hFF : sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.id_clear    = id_clear;
    assign bus.lut_update  = lut_update;
    assign bus.frame_drop  = frame_drop_q;
    assign bus.remap_valid = out_valid;
    assign bus.remap_data  = out_data;
endmodule

// File: tb/tb_hist_remap.sv
// tb/tb_hist_remap.sv - directed self-checking bench for hist_remap
module tb_hist_remap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   clr_cnt = 0;
    int   upd_cnt = 0;

    always #5 clk = ~clk;

    hist_remap_if bus();

    hist_remap #(.CLEAR_EN(1'b1), .INTERP_EN(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.id_clear) clr_cnt++;
        if (bus.lut_update) upd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string tag, input logic [7:0] d, input logic [7:0] exp);
        bus.video_data  = d;
        bus.video_valid = 1'b1;
        step();
        bus.video_valid = 1'b0;
        step();
        check({tag, "_v"}, 32'(bus.remap_valid), 32'd1);
        check(tag, 32'(bus.remap_data), 32'(exp));
    endtask

    task automatic run_build(input string tag, input logic [63:0] hv);
        int n;
        bus.id_value  = hv;
        bus.frame_end = 1'b1;
        step();
        bus.frame_end = 1'b0;
        check({tag, "_clr"}, 32'(bus.id_clear), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 1;
        while (!bus.lut_update && n < 200) begin
            step();
            n++;
        end
        check({tag, "_len"}, 32'(n), 32'd82);
        step();
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int   lu_cnt;
        int   lu_at;
        int   drp_cnt;
        int   drp_at;
        int   up0;
        int   guard;
        logic       pat [8];
        logic [7:0] dat [8];
        logic [7:0] last;

        bus.id_value    = '0;
        bus.frame_end   = 1'b0;
        bus.video_data  = '0;
        bus.video_valid = 1'b0;

        repeat (3) step();
        check("rst_data", 32'(bus.remap_data), 32'd0);
        check("rst_valid", 32'(bus.remap_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_upd", 32'(bus.lut_update), 32'd0);
        check("rst_drop", 32'(bus.frame_drop), 32'd0);
        check("rst_clr", 32'(bus.id_clear), 32'd0);
        rst = 1'b0;
        step();

        pix("id_00", 8'h00, 8'h00);
        pix("id_45", 8'h45, 8'h45);
        pix("id_ff", 8'hFF, 8'hFF);
        check("id_busy", 32'(bus.busy), 32'd0);
        check("id_noclr", 32'(clr_cnt), 32'd0);

        run_build("b10", {8{8'd10}});
        pix("b10_45", 8'h45, 8'h45);

        run_build("b0", 64'd100);
        pix("b0_10", 8'h10, 8'h80);
        pix("b0_40", 8'h40, 8'hFF);
        pix("b0_00", 8'h00, 8'h00);

        // bin0=1, bin1=2: lut = 85, 256, 256, ...
        run_build("b12", 64'h0201);
        pix("b12_00", 8'h00, 8'h00);
        pix("b12_1f", 8'h1F, 8'h52);
        pix("b12_20", 8'h20, 8'h55);
        pix("b12_e0", 8'hE0, 8'hFF);

        run_build("bz", 64'd0);
        pix("bz_a7", 8'hA7, 8'hA7);

        lu_cnt = 0; lu_at = 0; drp_cnt = 0; drp_at = 0;
        bus.id_value  = 64'd100;
        bus.frame_end = 1'b1;
        step();
        bus.frame_end = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (bus.lut_update) begin lu_cnt++; lu_at = c; end
            if (bus.frame_drop) begin drp_cnt++; drp_at = c; end
            bus.frame_end = (c == 10);
            step();
        end
        bus.frame_end = 1'b0;
        check("drop_upd_cnt", 32'(lu_cnt), 32'd1);
        check("drop_upd_at", 32'(lu_at), 32'd82);
        check("drop_cnt", 32'(drp_cnt), 32'd1);
        check("drop_at", 32'(drp_at), 32'd11);
        pix("drop_10", 8'h10, 8'h80);

        bus.id_value  = 64'h0201;
        bus.frame_end = 1'b1;
        step();
        bus.frame_end = 1'b0;
        repeat (29) step();
        check("rst_mid_busy", 32'(bus.busy), 32'd1);
        up0 = upd_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_idle", 32'(bus.busy), 32'd0);
        pix("rst_mid_10", 8'h10, 8'h10);
        pix("rst_mid_a7", 8'hA7, 8'hA7);
        repeat (100) step();
        check("rst_mid_noupd", 32'(upd_cnt), 32'(up0));

        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        dat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h00, 8'h00, 8'h00};
        last = 8'hA7;
        bus.id_value = {8{8'd10}};
        for (int k = 0; k < 8; k++) begin
            bus.video_valid = pat[k];
            bus.video_data  = dat[k];
            bus.frame_end   = (k == 1);
            step();
            if (k >= 1) begin
                if (pat[k-1]) last = dat[k-1];
                check($sformatf("strm_v%0d", k), 32'(bus.remap_valid), 32'(pat[k-1]));
                check($sformatf("strm_d%0d", k), 32'(bus.remap_data), 32'(last));
            end
        end
        bus.video_valid = 1'b0;
        bus.frame_end   = 1'b0;
        check("strm_busy", 32'(bus.busy), 32'd1);
        guard = 0;
        while (bus.busy && guard < 200) begin
            step();
            guard++;
        end
        check("strm_done", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
